// File: rtl/huffman_encoder_serial.sv
// ----------------------------------------------------------------------------
// huffman_encoder_serial
//   Serial Huffman encoder for the fixed 18-symbol code consumed by
//   huffman_decoder_serial. One symbol (1..18) is taken per sym_valid/sym_ready
//   transfer. Its codeword is then sent MSB-first, one bit per
//   bit_valid/bit_ready transfer, and bit_last marks the final bit.
//
// Ports
//   clk        in   1      rising-edge clock
//   rst        in   1      asynchronous active-high reset
//   sym        in   SYM_W  symbol to encode (0 and 19..63 are illegal)
//   sym_valid  in   1      sym is valid
//   sym_ready  out  1      encoder accepts sym this cycle (combinational)
//   bit_out    out  1      current code bit, registered
//   bit_valid  out  1      bit_out is valid, registered
//   bit_ready  in   1      downstream consumes bit_out this cycle
//   bit_last   out  1      bit_out is the final bit of the codeword, registered
//   sym_err    out  1      one-cycle pulse after an illegal symbol is dropped
//
// Configuration macro
//   HUFF_ENC_BACK2BACK_EN : when defined, a new symbol can be taken on the
//   transfer of the previous codeword's last bit, which gives a gap-free
//   bit stream. When undefined there is one idle cycle between codewords.
// ----------------------------------------------------------------------------
module huffman_encoder_serial #(
   parameter int SYM_W  = 6,
   parameter int CODE_W = 8,
   parameter int CNT_W  = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [SYM_W-1:0] sym,
   input  logic             sym_valid,
   output logic             sym_ready,
   output logic             bit_out,
   output logic             bit_valid,
   input  logic             bit_ready,
   output logic             bit_last,
   output logic             sym_err
);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t              state;
   logic [CODE_W-1:0]   shreg;
   logic [CNT_W-1:0]    cnt;

   logic [CODE_W-1:0]   lut_code;
   logic [CNT_W-1:0]    lut_len;
   logic                legal;
   logic                accept;
   logic                load;
   logic                bad_sym;
   logic                xfer;
   logic                done;

   // Code table. Codes are stored left-aligned so the first bit to send is
   // always in the MSB. A length of zero marks an illegal symbol.
   always_comb begin
      lut_code = '0;
      lut_len  = '0;
      case (sym)
         SYM_W'(1):  begin lut_len = CNT_W'(2); lut_code = 8'b0000_0000; end
         SYM_W'(2):  begin lut_len = CNT_W'(2); lut_code = 8'b0100_0000; end
         SYM_W'(3):  begin lut_len = CNT_W'(2); lut_code = 8'b1000_0000; end
         SYM_W'(4):  begin lut_len = CNT_W'(3); lut_code = 8'b1100_0000; end
         SYM_W'(5):  begin lut_len = CNT_W'(6); lut_code = 8'b1110_0000; end
         SYM_W'(6):  begin lut_len = CNT_W'(6); lut_code = 8'b1110_0100; end
         SYM_W'(7):  begin lut_len = CNT_W'(6); lut_code = 8'b1110_1000; end
         SYM_W'(8):  begin lut_len = CNT_W'(7); lut_code = 8'b1110_1100; end
         SYM_W'(9):  begin lut_len = CNT_W'(7); lut_code = 8'b1110_1110; end
         SYM_W'(10): begin lut_len = CNT_W'(7); lut_code = 8'b1111_0000; end
         SYM_W'(11): begin lut_len = CNT_W'(7); lut_code = 8'b1111_0010; end
         SYM_W'(12): begin lut_len = CNT_W'(7); lut_code = 8'b1111_0100; end
         SYM_W'(13): begin lut_len = CNT_W'(7); lut_code = 8'b1111_0110; end
         SYM_W'(14): begin lut_len = CNT_W'(7); lut_code = 8'b1111_1000; end
         SYM_W'(15): begin lut_len = CNT_W'(7); lut_code = 8'b1111_1010; end
         SYM_W'(16): begin lut_len = CNT_W'(7); lut_code = 8'b1111_1100; end
         SYM_W'(17): begin lut_len = CNT_W'(8); lut_code = 8'b1111_1110; end
         SYM_W'(18): begin lut_len = CNT_W'(8); lut_code = 8'b1111_1111; end
         default:    begin lut_len = '0;        lut_code = '0;          end
      endcase
   end

   assign legal = (lut_len != '0);

`ifdef HUFF_ENC_BACK2BACK_EN
   // bit_last is only ever high in SHIFT, so this also covers the final-bit
   // handover that keeps the stream free of bubbles.
   assign sym_ready = (state == IDLE) | ((state == SHIFT) & bit_last & bit_ready);
`else
   assign sym_ready = (state == IDLE);
`endif

   assign accept  = sym_valid & sym_ready;
   assign load    = accept & legal;
   assign bad_sym = accept & ~legal;
   assign xfer    = (state == SHIFT) & bit_valid & bit_ready;
   assign done    = xfer & (cnt == CNT_W'(1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         shreg     <= '0;
         cnt       <= '0;
         bit_out   <= 1'b0;
         bit_valid <= 1'b0;
         bit_last  <= 1'b0;
         sym_err   <= 1'b0;
      end else begin
         sym_err <= bad_sym;
         case (state)
            IDLE: begin
               if (load) begin
                  state     <= SHIFT;
                  shreg     <= lut_code;
                  cnt       <= lut_len;
                  bit_out   <= lut_code[CODE_W-1];
                  bit_valid <= 1'b1;
                  bit_last  <= (lut_len == CNT_W'(1));
               end
            end
            SHIFT: begin
               if (load) begin
                  // New codeword taken on the last-bit transfer: reload
                  // without leaving SHIFT.
                  shreg     <= lut_code;
                  cnt       <= lut_len;
                  bit_out   <= lut_code[CODE_W-1];
                  bit_valid <= 1'b1;
                  bit_last  <= (lut_len == CNT_W'(1));
               end else if (done) begin
                  state     <= IDLE;
                  shreg     <= shreg << 1;
                  cnt       <= '0;
                  bit_out   <= 1'b0;
                  bit_valid <= 1'b0;
                  bit_last  <= 1'b0;
               end else if (xfer) begin
                  shreg     <= shreg << 1;
                  cnt       <= cnt - CNT_W'(1);
                  bit_out   <= shreg[CODE_W-2];
                  bit_last  <= (cnt == CNT_W'(2));
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_huffman_encoder_serial.sv
module tb_huffman_encoder_serial;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [5:0] sym = '0;
   logic       sym_valid = 1'b0;
   logic       sym_ready;
   logic       bit_out;
   logic       bit_valid;
   logic       bit_ready = 1'b1;
   logic       bit_last;
   logic       sym_err;

   int total = 0;
   int bad   = 0;

   huffman_encoder_serial dut (
      .clk       (clk),
      .rst       (rst),
      .sym       (sym),
      .sym_valid (sym_valid),
      .sym_ready (sym_ready),
      .bit_out   (bit_out),
      .bit_valid (bit_valid),
      .bit_ready (bit_ready),
      .bit_last  (bit_last),
      .sym_err   (sym_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference codewords as text, straight from the code table.
   function automatic string code_of(input int s);
      case (s)
         1:  return "00";
         2:  return "01";
         3:  return "10";
         4:  return "110";
         5:  return "111000";
         6:  return "111001";
         7:  return "111010";
         8:  return "1110110";
         9:  return "1110111";
         10: return "1111000";
         11: return "1111001";
         12: return "1111010";
         13: return "1111011";
         14: return "1111100";
         15: return "1111101";
         16: return "1111110";
         17: return "11111110";
         18: return "11111111";
         default: return "";
      endcase
   endfunction

   // Model state: bits still owed for the codeword in flight.
   bit          q[$];
   logic        err_exp   = 1'b0;
   logic        hold_prev = 1'b0;
   logic        prev_bit  = 1'b0;
   logic        prev_last = 1'b0;
   logic [63:0] cap_bits  = '0;
   int          cap_n     = 0;
   int          err_n     = 0;
   int          cyc       = 0;
   int          xfer_cyc[$];

   always @(negedge clk) begin
      logic  exp_ready;
      string c;
      cyc++;
      if (rst) begin
         q.delete();
         err_exp   = 1'b0;
         hold_prev = 1'b0;
      end else begin
`ifdef HUFF_ENC_BACK2BACK_EN
         exp_ready = (q.size() == 0) || (q.size() == 1 && bit_ready);
`else
         exp_ready = (q.size() == 0);
`endif
         check("bit_valid", bit_valid, q.size() != 0);
         check("sym_err", sym_err, err_exp);
         check("sym_ready", sym_ready, exp_ready);
         if (q.size() != 0) begin
            check("bit_out", bit_out, q[0]);
            check("bit_last", bit_last, q.size() == 1);
         end
         if (hold_prev) begin
            check("hold_bit", bit_out, prev_bit);
            check("hold_last", bit_last, prev_last);
         end
         if (sym_err) err_n++;
         hold_prev = bit_valid && !bit_ready;
         prev_bit  = bit_out;
         prev_last = bit_last;
         if (bit_ready && q.size() != 0) begin
            cap_bits = {cap_bits[62:0], q[0]};
            cap_n++;
            xfer_cyc.push_back(cyc);
            void'(q.pop_front());
         end
         err_exp = 1'b0;
         if (sym_valid && exp_ready) begin
            c = code_of(int'(sym));
            if (c.len() == 0) begin
               err_exp = 1'b1;
               $display("sym %0d accepted: illegal, dropped", sym);
            end else begin
               for (int i = 0; i < c.len(); i++) q.push_back(c[i] == 8'd49);
               $display("sym %0d accepted: code %s", sym, c);
            end
         end
      end
   end

   task automatic send_seq(input int syms[$]);
      bit ok;
      sym_valid = 1'b1;
      foreach (syms[k]) begin
         sym = 6'(syms[k]);
         ok  = 1'b0;
         for (int n = 0; n < 60 && !ok; n++) begin
            @(negedge clk);
            if (sym_ready) ok = 1'b1;
         end
         check("accept_timeout", ok, 1'b1);
         @(posedge clk); #1;
      end
      sym_valid = 1'b0;
   endtask

   task automatic wait_idle();
      bit ok = 1'b0;
      for (int n = 0; n < 200 && !ok; n++) begin
         @(negedge clk);
         if (!bit_valid && q.size() == 0) ok = 1'b1;
      end
      check("idle_timeout", ok, 1'b1);
      @(posedge clk); #1;
   endtask

   initial begin
      int base;
      int e0;
      int span;
      #12;
      // Reset state
      check("rst_bit_out", bit_out, 1'b0);
      check("rst_bit_valid", bit_valid, 1'b0);
      check("rst_bit_last", bit_last, 1'b0);
      check("rst_sym_err", sym_err, 1'b0);
      check("rst_sym_ready", sym_ready, 1'b1);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;

      // 1: sym 1 -> 00
      base = cap_n;
      send_seq('{1});
      wait_idle();
      check("t1_count", cap_n - base, 2);
      check("t1_bits", cap_bits[1:0], 2'b00);

      // 2: sym 18 -> eight ones
      base = cap_n;
      send_seq('{18});
      wait_idle();
      check("t2_count", cap_n - base, 8);
      check("t2_bits", cap_bits[7:0], 8'hFF);

      // 3: sym 8 with bit_ready toggling 1,0,1,0...
      base = cap_n;
      send_seq('{8});
      for (int i = 0; i < 16; i++) begin
         bit_ready = (i % 2 == 0);
         @(posedge clk); #1;
      end
      bit_ready = 1'b1;
      wait_idle();
      check("t3_count", cap_n - base, 7);
      check("t3_bits", cap_bits[6:0], 7'b1110110);

      // 4: illegal symbols
      e0 = err_n;
      send_seq('{0});
      send_seq('{19});
      wait_idle();
      check("t4_err_pulses", err_n - e0, 2);

      // 5: back-to-back symbols, sym_valid held
      base = cap_n;
      send_seq('{4, 5, 2});
      wait_idle();
      check("t5_count", cap_n - base, 11);
      check("t5_bits", cap_bits[10:0], 11'b110_111000_01);
      span = xfer_cyc[xfer_cyc.size()-1] - xfer_cyc[base] + 1;
`ifdef HUFF_ENC_BACK2BACK_EN
      check("t5_span", span, 11);
`else
      check("t5_span", span, 13);
`endif

      // 6: async reset mid-codeword, then sym 3
      base = cap_n;
      sym = 6'd13;
      sym_valid = 1'b1;
      @(negedge clk);
      @(posedge clk); #1;
      sym_valid = 1'b0;
      for (int n = 0; n < 20 && (cap_n - base) < 3; n++) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("t6_bit_valid", bit_valid, 1'b0);
      check("t6_sym_ready", sym_ready, 1'b1);
      check("t6_bit_last", bit_last, 1'b0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      base = cap_n;
      send_seq('{3});
      wait_idle();
      check("t6_count", cap_n - base, 2);
      check("t6_bits", cap_bits[1:0], 2'b10);

      // Random traffic against the model
      for (int i = 0; i < 600; i++) begin
         sym_valid = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 9) == 0)
            sym = ($urandom_range(0, 1) == 0) ? 6'd0 : 6'($urandom_range(19, 63));
         else
            sym = 6'($urandom_range(1, 18));
         bit_ready = ($urandom_range(0, 3) != 0);
         @(posedge clk); #1;
      end
      sym_valid = 1'b0;
      bit_ready = 1'b1;
      wait_idle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
